// File: rtl/rom_uart_dump_pkg.sv
// Shared constants, state encodings and helpers for the ROM UART dump path.
// Frame constants live here so the dump and the loader receiver agree.
package rom_uart_dump_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DATA_BITS            = 8;
    localparam int BYTES_PER_WORD       = 4;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        D_IDLE,
        D_FETCH,
        D_LOAD,
        D_SEND,
        D_FIN
    } dump_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_STOP
    } tx_state_t;

    // Little-endian byte lane select
    function automatic logic [7:0] byte_sel(
        input logic [31:0] word,
        input logic [1:0]  idx
    );
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rom_uart_dump_tx_byte.sv
// 8N1 byte serializer with a valid/ready handshake.
// ready rises in the last stop-bit cycle so bytes can run back-to-back.
module rom_uart_dump_tx_byte
    import rom_uart_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       line
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t     state;
    tx_state_t     state_next;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;
    logic          last_bit;
    logic          take;

    assign bit_end  = (timer == TW'(CLKS_PER_BIT - 1));
    assign last_bit = (bit_idx == 3'(DATA_BITS - 1));
    assign take     = valid && ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= T_IDLE;
        else        state <= state_next;
    end

    // Next-state: start, eight data bits, stop, then reload or idle
    always_comb begin
        state_next = state;
        unique case (state)
            T_IDLE:  if (valid) state_next = T_START;
            T_START: if (bit_end) state_next = T_DATA;
            T_DATA:  if (bit_end && last_bit) state_next = T_STOP;
            T_STOP:  if (bit_end) state_next = valid ? T_START : T_IDLE;
            default: state_next = T_IDLE;
        endcase
    end

    // Handshake output: free when idle or finishing the stop bit
    always_comb begin
        ready = (state == T_IDLE) || (state == T_STOP && bit_end);
    end

    // Bit timer, shift register and registered line level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            line    <= IDLE_LEVEL;
        end else begin
            if (state == T_IDLE || bit_end) timer <= '0;
            else                            timer <= timer + 1'b1;

            if (take) begin
                shreg   <= data;
                bit_idx <= '0;
                line    <= START_LEVEL;
            end else if (bit_end) begin
                unique case (state)
                    T_START: line <= shreg[0];
                    T_DATA: begin
                        if (last_bit) begin
                            line <= STOP_LEVEL;
                        end else begin
                            line    <= shreg[1];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    default: line <= IDLE_LEVEL;
                endcase
            end
        end
    end

endmodule

// File: rtl/rom_uart_dump.sv
// ROM readback over UART: fetches WORD_COUNT words and sends each
// little-endian as four back-to-back 8N1 frames, then pulses done.
module rom_uart_dump
    import rom_uart_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int WORD_COUNT   = 64,
    parameter int AW           = 6
) (
    input  logic        clkIn,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        busy,
    output logic        done,
    output logic        uart_tx
);

    dump_state_t   state;
    dump_state_t   state_next;
    logic [AW-1:0] word_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   shift_word;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    tx_data;
    logic          last_byte;
    logic          last_word;

    assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));
    assign last_word = (word_idx == AW'(WORD_COUNT - 1));
    assign rom_addr  = 32'(word_idx);

    rom_uart_dump_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clkIn),
        .rst_n(rst_n),
        .valid(tx_valid),
        .data (tx_data),
        .ready(tx_ready),
        .line (uart_tx)
    );

    // State register
    always_ff @(posedge clkIn) begin
        if (!rst_n) state <= D_IDLE;
        else        state <= state_next;
    end

    // Next-state: fetch/load per word, send four bytes, finish after last word
    always_comb begin
        state_next = state;
        unique case (state)
            D_IDLE:  if (start) state_next = D_FETCH;
            D_FETCH: state_next = D_LOAD;
            D_LOAD:  state_next = D_SEND;
            D_SEND: begin
                if (tx_ready && last_byte)
                    state_next = last_word ? D_FIN : D_FETCH;
            end
            D_FIN:   state_next = D_IDLE;
            default: state_next = D_IDLE;
        endcase
    end

    // Outputs: byte 0 comes straight from ROM in LOAD, later bytes from shift_word
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = byte_sel(shift_word, byte_idx + 2'd1);
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            D_FETCH: busy = 1'b1;
            D_LOAD: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = rom_data[7:0];
            end
            D_SEND: begin
                busy     = 1'b1;
                tx_valid = tx_ready && !last_byte;
            end
            D_FIN:   done = 1'b1;
            default: ;
        endcase
    end

    // Word/byte counters and captured ROM word
    always_ff @(posedge clkIn) begin
        if (!rst_n) begin
            word_idx   <= '0;
            byte_idx   <= '0;
            shift_word <= '0;
        end else begin
            unique case (state)
                D_IDLE: if (start) word_idx <= '0;
                D_LOAD: begin
                    shift_word <= rom_data;
                    byte_idx   <= '0;
                end
                D_SEND: begin
                    if (tx_ready) begin
                        if (!last_byte)
                            byte_idx <= byte_idx + 2'd1;
                        else if (!last_word)
                            word_idx <= word_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
